// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg
// Shared types and encodings for the RV32I multi-cycle controller:
// FSM state enum, opcode constants, immediate-format codes, ALU operation
// codes, ALU decode classes, next-PC and write-back select codes, and the
// opcode-to-immediate-format helper.
package rv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_EXEC_I,
      S_MEMADR,
      S_MEMRD,
      S_MEMWR,
      S_WB,
      S_BRANCH,
      S_JAL,
      S_JALR,
      S_LUI,
      S_AUIPC,
      S_TRAP
   } state_e;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_U = 3'd3,
      IMM_J = 3'd4
   } imm_e;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_e;

   // What the current state wants from the ALU decoder.
   typedef enum logic [1:0] {
      ALU_CLS_ADD,
      ALU_CLS_R,
      ALU_CLS_I,
      ALU_CLS_BR
   } alu_cls_e;

   localparam logic [1:0] PC_PLUS4 = 2'd0;
   localparam logic [1:0] PC_IMM   = 2'd1;
   localparam logic [1:0] PC_ALU   = 2'd2;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;
   localparam logic [1:0] WB_IMM = 2'd3;

   // R-type and unknown opcodes have no immediate; they fall back to I.
   function automatic logic [2:0] imm_of(input logic [6:0] op);
      case (op)
         OP_STORE:         return IMM_S;
         OP_BRANCH:        return IMM_B;
         OP_LUI, OP_AUIPC: return IMM_U;
         OP_JAL:           return IMM_J;
         default:          return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/rv_alu_dec.sv
// rv_alu_dec
// Combinational ALU operation decode.
//   cls      : ALU usage class of the current controller state
//   funct3   : instr[14:12]
//   funct7_5 : instr[30]
//   alu_ctrl : ALU operation code (alu_e)
module rv_alu_dec
   import rv_ctrl_pkg::*;
(
   input  alu_cls_e   cls,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   output logic [3:0] alu_ctrl
);

   alu_e op_c;

   always_comb begin
      op_c = ALU_ADD;
      case (cls)
         ALU_CLS_R, ALU_CLS_I: begin
            case (funct3)
               3'b000:  op_c = (cls == ALU_CLS_R && funct7_5) ? ALU_SUB : ALU_ADD;
               3'b001:  op_c = ALU_SLL;
               3'b010:  op_c = ALU_SLT;
               3'b011:  op_c = ALU_SLTU;
               3'b100:  op_c = ALU_XOR;
               3'b101:  op_c = funct7_5 ? ALU_SRA : ALU_SRL;
               3'b110:  op_c = ALU_OR;
               default: op_c = ALU_AND;
            endcase
         end
         // BEQ/BNE compare by subtraction, BLT/BGE signed, BLTU/BGEU unsigned.
         ALU_CLS_BR: begin
            case (funct3)
               3'b100, 3'b101: op_c = ALU_SLT;
               3'b110, 3'b111: op_c = ALU_SLTU;
               default:        op_c = ALU_SUB;
            endcase
         end
         default: op_c = ALU_ADD;
      endcase
   end

   assign alu_ctrl = op_c;

endmodule

// File: rtl/rv_mc_control.sv
// rv_mc_control
// Multi-cycle RV32I main controller. Sequences fetch/decode/execute/memory/
// write-back over one shared memory port, drives all datapath selects and
// enables, and traps (sticky) on illegal opcodes or memory ack timeouts.
//   Inputs : clk, rst_n, op, funct3, funct7_5, br_taken, mem_ack
//   Outputs: mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, rf_we, wb_sel,
//            alu_a_sel, alu_b_sel, alu_ctrl, imm_type, illegal, bus_err,
//            retire
//
// state    | meaning
// ---------+--------------------------------------------------
// FETCH    | read instruction at PC, load IR and PC+4 on ack
// DECODE   | dispatch on opcode, trap on unknown opcode
// EXEC_R   | register-register ALU op
// EXEC_I   | register-immediate ALU op
// MEMADR   | rs1 + imm into ALU result register
// MEMRD    | data read at ALU result
// MEMWR    | data write at ALU result, retires on ack
// WB       | register file write (ALU or memory data)
// BRANCH   | compare rs1/rs2, take PC+imm if br_taken
// JAL      | rd = PC+4, PC = oldpc+imm
// JALR     | rd = PC+4, PC = (rs1+imm)&~1
// LUI      | rd = imm
// AUIPC    | rd = oldpc + imm
// TRAP     | everything idle until reset
module rv_mc_control
   import rv_ctrl_pkg::*;
#(
   parameter int ACK_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       br_taken,
   input  logic       mem_ack,
   output logic       mem_req,
   output logic       mem_we,
   output logic       addr_sel,
   output logic       ir_we,
   output logic       pc_we,
   output logic [1:0] pc_sel,
   output logic       rf_we,
   output logic [1:0] wb_sel,
   output logic       alu_a_sel,
   output logic       alu_b_sel,
   output logic [3:0] alu_ctrl,
   output logic [2:0] imm_type,
   output logic       illegal,
   output logic       bus_err,
   output logic       retire
);

   localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CW-1:0] TMO_LOAD = (ACK_TIMEOUT > 0) ? CW'(ACK_TIMEOUT - 1) : '0;

   state_e        state;
   logic [CW-1:0] tmo_cnt;
   logic          tmo_hit;
   alu_cls_e      alu_cls;

   // Down-counter reloads whenever no request is waiting; terminal count
   // in a request cycle without ack means ACK_TIMEOUT cycles went unanswered.
   assign tmo_hit = (ACK_TIMEOUT != 0) && mem_req && !mem_ack && (tmo_cnt == '0);

   rv_alu_dec u_alu_dec (
      .cls      (alu_cls),
      .funct3   (funct3),
      .funct7_5 (funct7_5),
      .alu_ctrl (alu_ctrl)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_FETCH;
         tmo_cnt <= TMO_LOAD;
         illegal <= 1'b0;
         bus_err <= 1'b0;
      end else begin
         if (!mem_req || mem_ack)
            tmo_cnt <= TMO_LOAD;
         else if (tmo_cnt != '0)
            tmo_cnt <= tmo_cnt - CW'(1);

         case (state)
            S_FETCH: begin
               if (mem_ack) begin
                  state <= S_DECODE;
               end else if (tmo_hit) begin
                  state   <= S_TRAP;
                  bus_err <= 1'b1;
               end
            end
            S_DECODE: begin
               case (op)
                  OP_R:      state <= S_EXEC_R;
                  OP_IMM:    state <= S_EXEC_I;
                  OP_LOAD:   state <= S_MEMADR;
                  OP_STORE:  state <= S_MEMADR;
                  OP_BRANCH: state <= S_BRANCH;
                  OP_JAL:    state <= S_JAL;
                  OP_JALR:   state <= S_JALR;
                  OP_LUI:    state <= S_LUI;
                  OP_AUIPC:  state <= S_AUIPC;
                  default: begin
                     state   <= S_TRAP;
                     illegal <= 1'b1;
                  end
               endcase
            end
            S_EXEC_R, S_EXEC_I: state <= S_WB;
            S_MEMADR: state <= (op == OP_STORE) ? S_MEMWR : S_MEMRD;
            S_MEMRD, S_MEMWR: begin
               if (mem_ack) begin
                  state <= (state == S_MEMRD) ? S_WB : S_FETCH;
               end else if (tmo_hit) begin
                  state   <= S_TRAP;
                  bus_err <= 1'b1;
               end
            end
            S_WB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC: state <= S_FETCH;
            S_TRAP:  state <= S_TRAP;
            default: state <= S_TRAP;
         endcase
      end
   end

   // Outputs are forced low while rst_n is asserted so a mid-operation reset
   // kills the request and every enable immediately, not at the next edge.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = PC_PLUS4;
      rf_we     = 1'b0;
      wb_sel    = WB_ALU;
      alu_a_sel = 1'b0;
      alu_b_sel = 1'b0;
      alu_cls   = ALU_CLS_ADD;
      imm_type  = IMM_I;
      retire    = 1'b0;
      if (rst_n) begin
         if (state != S_FETCH && state != S_TRAP)
            imm_type = imm_of(op);
         case (state)
            S_FETCH: begin
               mem_req = 1'b1;
               ir_we   = mem_ack;
               pc_we   = mem_ack;
            end
            S_EXEC_R: alu_cls = ALU_CLS_R;
            S_EXEC_I: begin
               alu_cls   = ALU_CLS_I;
               alu_b_sel = 1'b1;
            end
            S_MEMADR: alu_b_sel = 1'b1;
            S_MEMRD: begin
               mem_req  = 1'b1;
               addr_sel = 1'b1;
            end
            S_MEMWR: begin
               mem_req  = 1'b1;
               mem_we   = 1'b1;
               addr_sel = 1'b1;
               retire   = mem_ack;
            end
            S_WB: begin
               rf_we  = 1'b1;
               wb_sel = (op == OP_LOAD) ? WB_MEM : WB_ALU;
               retire = 1'b1;
            end
            S_BRANCH: begin
               alu_cls = ALU_CLS_BR;
               pc_we   = br_taken;
               pc_sel  = PC_IMM;
               retire  = 1'b1;
            end
            S_JAL: begin
               rf_we  = 1'b1;
               wb_sel = WB_PC4;
               pc_we  = 1'b1;
               pc_sel = PC_IMM;
               retire = 1'b1;
            end
            S_JALR: begin
               alu_b_sel = 1'b1;
               rf_we     = 1'b1;
               wb_sel    = WB_PC4;
               pc_we     = 1'b1;
               pc_sel    = PC_ALU;
               retire    = 1'b1;
            end
            S_LUI: begin
               rf_we  = 1'b1;
               wb_sel = WB_IMM;
               retire = 1'b1;
            end
            S_AUIPC: begin
               alu_a_sel = 1'b1;
               alu_b_sel = 1'b1;
               rf_we     = 1'b1;
               wb_sel    = WB_ALU;
               retire    = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rv_mc_control.sv
// tb_rv_mc_control
// Self-checking bench for rv_mc_control. Each instruction is expanded from
// its RISC-V class into a per-cycle list of expected control outputs, then
// replayed against the DUT while the bench plays the memory.
module tb_rv_mc_control;
   import rv_ctrl_pkg::*;

   localparam int TMO = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] op = '0;
   logic [2:0] funct3 = '0;
   logic       funct7_5 = 1'b0;
   logic       br_taken = 1'b0;
   logic       mem_ack = 1'b0;
   logic       mem_req, mem_we, addr_sel, ir_we, pc_we, rf_we;
   logic [1:0] pc_sel, wb_sel;
   logic       alu_a_sel, alu_b_sel;
   logic [3:0] alu_ctrl;
   logic [2:0] imm_type;
   logic       illegal, bus_err, retire;

   rv_mc_control #(.ACK_TIMEOUT(TMO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .op        (op),
      .funct3    (funct3),
      .funct7_5  (funct7_5),
      .br_taken  (br_taken),
      .mem_ack   (mem_ack),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .addr_sel  (addr_sel),
      .ir_we     (ir_we),
      .pc_we     (pc_we),
      .pc_sel    (pc_sel),
      .rf_we     (rf_we),
      .wb_sel    (wb_sel),
      .alu_a_sel (alu_a_sel),
      .alu_b_sel (alu_b_sel),
      .alu_ctrl  (alu_ctrl),
      .imm_type  (imm_type),
      .illegal   (illegal),
      .bus_err   (bus_err),
      .retire    (retire)
   );

   always #5 clk = ~clk;

   // -1 in an int field means "not checked this cycle".
   typedef struct {
      bit ack;
      bit br;
      bit req;
      bit we;
      bit asel;
      bit irwe;
      bit pcwe;
      int pcsel;
      bit rfwe;
      int wbsel;
      int asl;
      int bsl;
      int aluc;
      int immt;
      bit ret;
      bit ill;
      bit berr;
   } cyc_t;

   cyc_t sched[$];
   bit   exp_ill = 1'b0;
   bit   exp_berr = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic cyc_t blank(input int immt);
      cyc_t c;
      c.ack = 1'b0; c.br = 1'($urandom_range(0, 1));
      c.req = 1'b0; c.we = 1'b0; c.asel = 1'b0; c.irwe = 1'b0; c.pcwe = 1'b0;
      c.pcsel = -1; c.rfwe = 1'b0; c.wbsel = -1; c.asl = -1; c.bsl = -1;
      c.aluc = -1; c.immt = immt; c.ret = 1'b0; c.ill = exp_ill; c.berr = exp_berr;
      return c;
   endfunction

   function automatic bit is_legal(input logic [6:0] o);
      return o == 7'b0110011 || o == 7'b0010011 || o == 7'b0000011 ||
             o == 7'b0100011 || o == 7'b1100011 || o == 7'b1101111 ||
             o == 7'b1100111 || o == 7'b0110111 || o == 7'b0010111;
   endfunction

   function automatic int imm_exp(input logic [6:0] o);
      case (o)
         7'b0100011:             return 1;
         7'b1100011:             return 2;
         7'b0110111, 7'b0010111: return 3;
         7'b1101111:             return 4;
         7'b0110011:             return -1;
         default:                return 0;
      endcase
   endfunction

   function automatic int alu_exp(input bit rtype, input logic [2:0] f3, input bit f7);
      int base [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      if (f3 == 3'd0 && rtype && f7) return ALU_SUB;
      if (f3 == 3'd5 && f7) return ALU_SRA;
      return base[f3];
   endfunction

   function automatic int br_alu_exp(input logic [2:0] f3);
      if (!f3[2]) return ALU_SUB;
      return f3[1] ? ALU_SLTU : ALU_SLT;
   endfunction

   task automatic push_trap();
      for (int i = 0; i < 5; i++) sched.push_back(blank(-1));
   endtask

   // Waits, then an ack cycle handed back for the caller to decorate; a wait
   // count of TMO or more expands into the timeout trap instead.
   task automatic push_access(input int w, input bit we, input bit asel, input int immt,
                              output bit to, output cyc_t last);
      cyc_t c;
      to = 1'b0;
      for (int i = 0; i < w && i < TMO; i++) begin
         c = blank(immt); c.req = 1'b1; c.we = we; c.asel = asel;
         sched.push_back(c);
      end
      last = blank(immt); last.req = 1'b1; last.we = we; last.asel = asel; last.ack = 1'b1;
      if (w >= TMO) begin
         to = 1'b1;
         exp_berr = 1'b1;
         push_trap();
      end
   endtask

   task automatic build(input logic [6:0] o, input logic [2:0] f3, input bit f7,
                        input bit br, input int fw, input int mw);
      cyc_t c;
      bit   to;
      int   im;
      im = imm_exp(o);
      push_access(fw, 1'b0, 1'b0, -1, to, c);
      if (to) return;
      c.irwe = 1'b1; c.pcwe = 1'b1; c.pcsel = PC_PLUS4;
      sched.push_back(c);
      if (!is_legal(o)) begin
         sched.push_back(blank(-1));
         exp_ill = 1'b1;
         push_trap();
         return;
      end
      sched.push_back(blank(im));
      c = blank(im);
      case (o)
         7'b0110011, 7'b0010011: begin
            c.asl = 0; c.bsl = (o == 7'b0010011) ? 1 : 0;
            c.aluc = alu_exp(o == 7'b0110011, f3, f7);
            sched.push_back(c);
            c = blank(im); c.rfwe = 1'b1; c.wbsel = WB_ALU; c.ret = 1'b1;
            sched.push_back(c);
         end
         7'b0000011, 7'b0100011: begin
            c.asl = 0; c.bsl = 1; c.aluc = ALU_ADD;
            sched.push_back(c);
            push_access(mw, o == 7'b0100011, 1'b1, im, to, c);
            if (to) return;
            if (o == 7'b0100011) begin
               c.ret = 1'b1;
               sched.push_back(c);
            end else begin
               sched.push_back(c);
               c = blank(im); c.rfwe = 1'b1; c.wbsel = WB_MEM; c.ret = 1'b1;
               sched.push_back(c);
            end
         end
         7'b1100011: begin
            c.br = br; c.asl = 0; c.bsl = 0; c.aluc = br_alu_exp(f3);
            c.pcwe = br; c.pcsel = PC_IMM; c.ret = 1'b1;
            sched.push_back(c);
         end
         7'b1101111: begin
            c.rfwe = 1'b1; c.wbsel = WB_PC4; c.pcwe = 1'b1; c.pcsel = PC_IMM; c.ret = 1'b1;
            sched.push_back(c);
         end
         7'b1100111: begin
            c.asl = 0; c.bsl = 1; c.aluc = ALU_ADD;
            c.rfwe = 1'b1; c.wbsel = WB_PC4; c.pcwe = 1'b1; c.pcsel = PC_ALU; c.ret = 1'b1;
            sched.push_back(c);
         end
         7'b0110111: begin
            c.rfwe = 1'b1; c.wbsel = WB_IMM; c.ret = 1'b1;
            sched.push_back(c);
         end
         default: begin
            c.asl = 1; c.bsl = 1; c.aluc = ALU_ADD;
            c.rfwe = 1'b1; c.wbsel = WB_ALU; c.ret = 1'b1;
            sched.push_back(c);
         end
      endcase
   endtask

   // Entered and left at posedge+1; n < 0 runs the whole schedule.
   task automatic run_sched(input int n);
      cyc_t c;
      while (sched.size() > 0 && n != 0) begin
         c = sched.pop_front();
         n--;
         mem_ack  = c.req ? c.ack : 1'($urandom_range(0, 1));
         br_taken = c.br;
         @(negedge clk);
         chk("mem_req", mem_req, c.req);
         chk("mem_we", mem_we, c.we);
         chk("ir_we", ir_we, c.irwe);
         chk("pc_we", pc_we, c.pcwe);
         chk("rf_we", rf_we, c.rfwe);
         chk("retire", retire, c.ret);
         chk("illegal", illegal, c.ill);
         chk("bus_err", bus_err, c.berr);
         if (c.req)        chk("addr_sel", addr_sel, c.asel);
         if (c.pcsel >= 0) chk("pc_sel", pc_sel, c.pcsel);
         if (c.wbsel >= 0) chk("wb_sel", wb_sel, c.wbsel);
         if (c.asl >= 0)   chk("alu_a_sel", alu_a_sel, c.asl);
         if (c.bsl >= 0)   chk("alu_b_sel", alu_b_sel, c.bsl);
         if (c.aluc >= 0)  chk("alu_ctrl", alu_ctrl, c.aluc);
         if (c.immt >= 0)  chk("imm_type", imm_type, c.immt);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input logic [6:0] o, input logic [2:0] f3, input bit f7,
                        input bit br, input int fw, input int mw);
      op = o; funct3 = f3; funct7_5 = f7;
      build(o, f3, f7, br, fw, mw);
      run_sched(-1);
   endtask

   // Called at posedge+1; returns at posedge+2 with the DUT in its first
   // post-reset FETCH cycle.
   task automatic do_reset();
      rst_n = 1'b0;
      mem_ack = 1'b0;
      #1;
      chk("reset_outs",
          {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, rf_we, wb_sel, alu_a_sel,
           alu_b_sel, alu_ctrl, imm_type, illegal, bus_err, retire}, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_ill = 1'b0;
      exp_berr = 1'b0;
      sched.delete();
      #1;
      chk("post_reset_req", mem_req, 1'b1);
      chk("post_reset_addr_sel", addr_sel, 1'b0);
   endtask

   initial begin
      logic [6:0] legal_ops [9];
      legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                    7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

      @(posedge clk);
      #1;
      do_reset();

      issue(7'b0010011, 3'b000, 1'b0, 1'b0, 0, 0);   // ADDI
      issue(7'b0000011, 3'b010, 1'b0, 1'b0, 2, 2);   // LW, 2 waits each access
      issue(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);   // BEQ taken
      issue(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0);   // BEQ not taken
      issue(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);   // SUB
      issue(7'b0010011, 3'b101, 1'b1, 1'b0, 1, 0);   // SRAI
      issue(7'b0110011, 3'b101, 1'b1, 1'b0, 0, 0);   // SRA
      issue(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0);   // JAL
      issue(7'b1100111, 3'b000, 1'b0, 1'b0, 0, 0);   // JALR
      issue(7'b0110111, 3'b000, 1'b0, 1'b0, 0, 0);   // LUI
      issue(7'b0010111, 3'b000, 1'b0, 1'b0, 0, 0);   // AUIPC
      issue(7'b0100011, 3'b010, 1'b0, 1'b0, 0, TMO - 1); // SW, ack on last allowed cycle
      issue(7'b0010011, 3'b000, 1'b0, 1'b0, TMO - 1, 0); // fetch ack on last allowed cycle

      for (int i = 0; i < 150; i++) begin
         issue(legal_ops[$urandom_range(0, 8)], 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1));
      end

      // Fetch never acknowledged.
      issue(7'b0010011, 3'b000, 1'b0, 1'b0, TMO, 0);
      do_reset();
      issue(7'b0110011, 3'b111, 1'b0, 1'b0, 0, 0);

      // Load data read never acknowledged.
      issue(7'b0000011, 3'b010, 1'b0, 1'b0, 1, TMO);
      do_reset();

      // Illegal opcode (SYSTEM).
      issue(7'b1110011, 3'b000, 1'b0, 1'b0, 0, 0);
      do_reset();

      // Reset during a store's memory wait.
      op = 7'b0100011; funct3 = 3'b010; funct7_5 = 1'b0;
      build(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 3);
      run_sched(4);
      mem_ack = 1'b0;
      #1;
      chk("memwr_wait_req", mem_req, 1'b1);
      chk("memwr_wait_we", mem_we, 1'b1);
      chk("memwr_wait_addr_sel", addr_sel, 1'b1);
      do_reset();
      issue(7'b0010011, 3'b110, 1'b0, 1'b0, 0, 0);
      issue(7'b0000011, 3'b000, 1'b0, 1'b0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rv_mc_control.md
# rv_mc_control

Multi-cycle main controller for the RV32I core. It sequences one instruction at a time through fetch, decode, execute, memory and write-back over a shared single-port memory interface. It drives every datapath select and write enable, including the immediate-type select consumed by the immediate generator. It also traps on illegal opcodes and on memory timeouts.

## Interface
- `ACK_TIMEOUT`, default 16: maximum number of cycles `mem_req` may stay high without `mem_ack`. A value of 0 disables the timeout.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `op` in 7: opcode field `instr[6:0]` from the instruction register.
- `funct3` in 3: `instr[14:12]`.
- `funct7_5` in 1: `instr[30]`.
- `br_taken` in 1: branch comparator result, valid in the BRANCH state.
- `mem_ack` in 1: memory completion for the current request.
- `mem_req` out 1: memory request.
- `mem_we` out 1: store request.
- `addr_sel` out 1: memory address source. 0 = PC, 1 = ALU result register.
- `ir_we` out 1: instruction register load.
- `pc_we` out 1: PC load.
- `pc_sel` out 2: next-PC source. 0 = PC+4, 1 = PC+imm, 2 = ALU&~1.
- `rf_we` out 1: register file write.
- `wb_sel` out 2: write-back source. 0 = ALU, 1 = memory data, 2 = PC+4, 3 = imm.
- `alu_a_sel` out 1: ALU operand A. 0 = rs1, 1 = PC.
- `alu_b_sel` out 1: ALU operand B. 0 = rs2, 1 = imm.
- `alu_ctrl` out 4: ALU operation, encoded per the package.
- `imm_type` out 3: immediate format. I = 0, S = 1, B = 2, U = 3, J = 4.
- `illegal` out 1: sticky trap, illegal opcode.
- `bus_err` out 1: sticky trap, memory timeout.
- `retire` out 1: one-cycle pulse when an instruction completes.

## Operation
- **States:** FETCH, DECODE, EXEC_R, EXEC_I, MEMADR, MEMRD, MEMWR, WB, BRANCH, JAL, JALR, LUI, AUIPC, TRAP.
- **FETCH:**
  - Drives `mem_req=1`, `addr_sel=0`, `mem_we=0`.
  - On `mem_ack`: pulse `ir_we`, pulse `pc_we` with `pc_sel=0`, go to DECODE.
- **DECODE dispatch by `op`:**
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 → MEMADR
  - 0100011 → MEMADR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - Any other opcode → TRAP with `illegal=1`.
  - `imm_type` is driven from `op` in DECODE and every later state of the instruction.
- **EXEC_R / EXEC_I:**
  - `alu_ctrl` is decoded from `funct3`.
  - `funct7_5` selects SUB vs ADD for R-type only.
  - `funct7_5` selects SRA vs SRL for both R-type and I-type.
  - EXEC_I uses `alu_b_sel=1`.
  - Both go to WB with `wb_sel=0`.
- **MEMADR:**
  - Computes ALU ADD with rs1 and imm.
  - Load → MEMRD; store → MEMWR.
- **MEMRD:**
  - Drives `mem_req=1`, `addr_sel=1`.
  - On `mem_ack` → WB with `wb_sel=1`.
- **MEMWR:**
  - Drives `mem_req=1`, `mem_we=1`, `addr_sel=1`.
  - On `mem_ack` → FETCH with `retire`.
- **BRANCH:**
  - ALU compares rs1 and rs2.
  - `pc_we = br_taken`, `pc_sel=1`.
  - Goes to FETCH with `retire`.
- **JAL:**
  - `rf_we=1`, `wb_sel=2`.
  - `pc_we=1`, `pc_sel=1`.
  - Goes to FETCH with `retire`.
- **JALR:**
  - ALU ADD with rs1 and imm.
  - `rf_we=1`, `wb_sel=2`.
  - `pc_we=1`, `pc_sel=2`.
  - Goes to FETCH with `retire`.
- **LUI:** `rf_we=1`, `wb_sel=3`, then FETCH with `retire`.
- **AUIPC:**
  - ALU ADD with PC and imm.
  - `rf_we=1`, `wb_sel=0`.
  - Goes to FETCH with `retire`.
- **WB:** `rf_we=1`, then FETCH with `retire`.
- **Control and PC convention:**
  - All control outputs are decoded combinationally from the current state.
  - `illegal` and `bus_err` are the only registered outputs.
  - The PC seen in post-FETCH states is already PC+4. The datapath holds the old PC (`oldpc`) for PC-relative use.
- **Timeout:**
  - A counter runs while `mem_req` is high and clears on `mem_ack` or on leaving the state.
  - When it reaches `ACK_TIMEOUT`, go to TRAP with `bus_err=1`.
- **TRAP:**
  - All enables and `mem_req` are 0.
  - The block stays in TRAP until reset.

## Timing
- **Reset values:** all outputs 0, state FETCH.
  - `mem_req` rises combinationally in the first cycle after `rst_n` deasserts.
  - Assertion of `rst_n` mid-operation drops `mem_req` and all enables immediately, with no further writes.
- **Latency with zero-wait memory** (`mem_ack` in the same cycle as `mem_req`):
  - Branch, JAL, JALR, LUI, AUIPC: 3 cycles.
  - R-type, I-type, store: 4 cycles.
  - Load: 5 cycles.
  - Each wait cycle adds one cycle.
- **Memory handshake:**
  - `mem_req`, `mem_we` and `addr_sel` stay stable until `mem_ack` is sampled.
  - `mem_ack` while `mem_req=0` is ignored.
  - If the timeout and `mem_ack` occur in the same cycle, the ack wins.
- **`retire`:** high for exactly 1 cycle per instruction, never in TRAP.

## Structure
- **Package `rv_ctrl_pkg`:**
  - State enum.
  - Opcode constants.
  - `imm_type` encodings.
  - `alu_ctrl` encodings: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - `pc_sel` and `wb_sel` encodings.
- **Sub-module `rv_alu_dec`:** combinational mapping of (state class, `funct3`, `funct7_5`) to `alu_ctrl`.

## Test plan
- **ADDI** (`op`=0010011, `funct3`=000), zero-wait: states FETCH → DECODE → EXEC_I → WB.
  - `imm_type`=0, `alu_ctrl`=ADD, `rf_we` in cycle 4, `retire` in cycle 4.
- **LW with 2 wait cycles on each access:** 9 cycles total.
  - `mem_req`/`addr_sel` stable during the waits.
  - `wb_sel`=1 in WB.
- **BEQ:**
  - With `br_taken`=1: `pc_we`=1 and `pc_sel`=1 in cycle 3.
  - With `br_taken`=0: `pc_we`=0 and `retire`=1.
- **`op`=1110011:** TRAP after DECODE, `illegal`=1, no `rf_we`/`mem_req` thereafter, until reset.
- **`ACK_TIMEOUT`=4 and `mem_ack` never asserted:**
  - `bus_err` rises after 4 request cycles.
  - Repeat with ack on cycle 4: normal flow, no error.
- **Reset asserted during MEMWR wait:** `mem_req`=0 asynchronously, and after release `mem_req`=1 with `addr_sel`=0.
